// File: rtl/scratchpad_bank_pkg.sv
// -----------------------------------------------------------------------------
// scratchpad_bank_pkg
//   Shared types and default geometry for the scratchpad bank requester.
//   - bank_req_state_t : requester FSM states
//   - bank_cmd_t       : one client command (write flag, start address,
//                        beat count, byte-lane mask) at the default geometry
//   - data_width()     : word width helper (lanes * bits per lane)
// -----------------------------------------------------------------------------
package scratchpad_bank_pkg;

  localparam int BANK_SIZE       = 1024;
  localparam int BANK_ADDR_WIDTH = $clog2(BANK_SIZE);
  localparam int BANK_COL_WIDTH  = 8;
  localparam int BANK_NB_COL     = 4;
  localparam int BANK_DATA_WIDTH = BANK_NB_COL * BANK_COL_WIDTH;
  localparam int BANK_MAX_BURST  = 16;
  localparam int BANK_LEN_WIDTH  = $clog2(BANK_MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } bank_req_state_t;

  typedef struct packed {
    logic                       write;
    logic [BANK_ADDR_WIDTH-1:0] address;
    logic [BANK_LEN_WIDTH-1:0]  length;
    logic [BANK_NB_COL-1:0]     mask;
  } bank_cmd_t;

  function automatic int data_width(input int nb_col, input int col_width);
    return nb_col * col_width;
  endfunction

endpackage

// File: rtl/bank_rsp_buffer.sv
// -----------------------------------------------------------------------------
// bank_rsp_buffer
//   Two-entry FIFO of {data, last} that absorbs the bank's read latency.
//   Ports:
//     clock, resetn          : clock, synchronous active-low reset
//     push, push_data/last   : write one entry
//     pop                    : remove the head entry (same-cycle push allowed)
//     head_data, head_last   : current head entry (meaningful when !empty)
//     full, empty, count     : occupancy status
// -----------------------------------------------------------------------------
module bank_rsp_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic [DATA_WIDTH-1:0] data_d [2];
  logic [1:0]            last_q;
  logic [1:0]            last_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);
  assign count     = count_q;
  assign head_data = data_q[rd_ptr_q];
  assign head_last = last_q[rd_ptr_q];

  always_comb begin
    data_d   = data_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      data_d[wr_ptr_q] = push_data;
      last_d[wr_ptr_q] = push_last;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      last_q   <= 2'b00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // Payload needs no reset: it is only observed while the entry is occupied.
  always_ff @(posedge clock) begin
    data_q <= data_d;
  end

  a_no_overflow : assert property (@(posedge clock) disable iff (!resetn)
    !(push && full && !pop));

  a_no_underflow : assert property (@(posedge clock) disable iff (!resetn)
    !(pop && empty));

endmodule

// File: rtl/memory_bank_requester.sv
// -----------------------------------------------------------------------------
// memory_bank_requester
//   Initiator-side controller for one single-port, byte-writable scratchpad
//   bank. Accepts single/burst read or write commands, streams write beats
//   straight to the bank, and returns read beats through a 2-entry buffer
//   that hides the bank's fixed 1-cycle read latency.
//   Ports:
//     clock, resetn                         : clock, sync active-low reset
//     req_*                                 : command channel (valid/ready)
//     wdata_valid/ready, wdata              : write beat stream
//     rsp_valid/ready, rsp_data, rsp_last   : read beat stream
//     bank_enable/address/write_enable/
//     write_data, bank_read_data            : bank interface
// -----------------------------------------------------------------------------
module memory_bank_requester
  import scratchpad_bank_pkg::*;
#(
  parameter  int SIZE       = BANK_SIZE,
  parameter  int ADDR_WIDTH = $clog2(SIZE),
  parameter  int COL_WIDTH  = BANK_COL_WIDTH,
  parameter  int NB_COL     = BANK_NB_COL,
  parameter  int MAX_BURST  = BANK_MAX_BURST,
  parameter  int LEN_WIDTH  = $clog2(MAX_BURST + 1),
  localparam int DATA_WIDTH = data_width(NB_COL, COL_WIDTH)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [LEN_WIDTH-1:0]  req_length,
  input  logic [NB_COL-1:0]     req_mask,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  bank_enable,
  output logic [ADDR_WIDTH-1:0] bank_address,
  output logic [NB_COL-1:0]     bank_write_enable,
  output logic [DATA_WIDTH-1:0] bank_write_data,
  input  logic [DATA_WIDTH-1:0] bank_read_data
);

  bank_req_state_t       state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;       // beats still to transfer
  logic [NB_COL-1:0]     mask_q, mask_d;
  logic                  inflight_q, inflight_d; // read issued last cycle
  logic                  inflight_last_q, inflight_last_d;

  bank_cmd_t             cmd;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  write_beat;
  logic                  read_issue;
  logic                  read_credit_ok;
  logic [2:0]            credit_used;

  logic                  buf_pop;
  logic                  buf_full;
  logic                  buf_empty;
  logic [1:0]            buf_count;
  logic                  buf_head_last;

  assign cmd = '{write: req_write, address: req_address, length: req_length, mask: req_mask};

  assign last_beat = (beats_q == LEN_WIDTH'(1));

  // SIZE need not be a power of two, so wrap explicitly.
  assign addr_next = (addr_q == ADDR_WIDTH'(SIZE - 1)) ? '0 : addr_q + 1'b1;

  // Slots already committed: buffered + in flight, minus the one leaving
  // this cycle. Counting the pop keeps back-to-back issue at full rate.
  assign credit_used    = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, buf_pop};
  assign read_credit_ok = (credit_used < 3'd2);

  assign rsp_valid = resetn && !buf_empty;
  assign rsp_last  = rsp_valid && buf_head_last;
  assign buf_pop   = rsp_valid && rsp_ready;

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    beats_d           = beats_q;
    mask_d            = mask_q;
    inflight_d        = 1'b0;
    inflight_last_d   = 1'b0;
    req_ready         = 1'b0;
    wdata_ready       = 1'b0;
    write_beat        = 1'b0;
    read_issue        = 1'b0;
    bank_enable       = 1'b0;
    bank_address      = addr_q;
    bank_write_enable = '0;
    bank_write_data   = '0;

    // Outputs stay quiet while reset is held, even before the state clears.
    if (resetn) begin
      case (state_q)
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            addr_d  = cmd.address;
            mask_d  = cmd.mask;
            beats_d = (cmd.length == '0) ? LEN_WIDTH'(1) : cmd.length;
            state_d = cmd.write ? WRITE : READ;
          end
        end

        WRITE: begin
          wdata_ready = 1'b1;
          if (wdata_valid) begin
            write_beat        = 1'b1;
            bank_enable       = 1'b1;
            bank_write_enable = mask_q;
            bank_write_data   = wdata;
            addr_d            = addr_next;
            beats_d           = beats_q - LEN_WIDTH'(1);
            if (last_beat) begin
              state_d = IDLE;
            end
          end
        end

        READ: begin
          if (read_credit_ok) begin
            read_issue      = 1'b1;
            bank_enable     = 1'b1;
            inflight_d      = 1'b1;
            inflight_last_d = last_beat;
            addr_d          = addr_next;
            beats_d         = beats_q - LEN_WIDTH'(1);
            if (last_beat) begin
              state_d = DRAIN;
            end
          end
        end

        DRAIN: begin
          if (!inflight_q && buf_empty) begin
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      beats_q         <= '0;
      mask_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      beats_q         <= beats_d;
      mask_q          <= mask_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  // Bank data arrives the cycle after the issue strobe.
  bank_rsp_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_buffer (
    .clock     (clock),
    .resetn    (resetn),
    .push      (inflight_q),
    .push_data (bank_read_data),
    .push_last (inflight_last_q),
    .pop       (buf_pop),
    .head_data (rsp_data),
    .head_last (buf_head_last),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  a_bank_enable_cause : assert property (@(posedge clock) disable iff (!resetn)
    bank_enable == (write_beat || read_issue));

  a_no_issue_when_full : assert property (@(posedge clock) disable iff (!resetn)
    read_issue |-> !buf_full || buf_pop);

endmodule

// File: tb/tb_memory_bank_requester.sv
module tb_memory_bank_requester;
  import scratchpad_bank_pkg::*;

  localparam int SIZE = 1024;
  localparam int AW   = 10;
  localparam int LW   = 5;
  localparam int NBC  = 4;
  localparam int DW   = 32;

  logic          clock = 1'b0;
  logic          resetn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_address;
  logic [LW-1:0] req_length;
  logic [NBC-1:0] req_mask;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rsp_valid, rsp_ready, rsp_last;
  logic [DW-1:0] rsp_data;
  logic          bank_enable;
  logic [AW-1:0] bank_address;
  logic [NBC-1:0] bank_write_enable;
  logic [DW-1:0] bank_write_data;
  logic [DW-1:0] bank_read_data;

  always #5 clock = ~clock;

  memory_bank_requester dut (
    .clock             (clock),
    .resetn            (resetn),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_address       (req_address),
    .req_length        (req_length),
    .req_mask          (req_mask),
    .wdata_valid       (wdata_valid),
    .wdata_ready       (wdata_ready),
    .wdata             (wdata),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_data          (rsp_data),
    .rsp_last          (rsp_last),
    .bank_enable       (bank_enable),
    .bank_address      (bank_address),
    .bank_write_enable (bank_write_enable),
    .bank_write_data   (bank_write_data),
    .bank_read_data    (bank_read_data)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- bank model: byte-writable, 1-cycle read ----------------
  logic [DW-1:0] bank_mem [SIZE];
  always @(posedge clock) begin
    if (bank_enable) begin
      for (int l = 0; l < NBC; l++) begin
        if (bank_write_enable[l]) bank_mem[bank_address][l*8 +: 8] <= bank_write_data[l*8 +: 8];
      end
      bank_read_data <= bank_mem[bank_address];
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0]  ref_mem [SIZE];
  logic [AW-1:0]  exp_waddr_q [$];
  logic [NBC-1:0] exp_wmask_q [$];
  logic [AW-1:0]  exp_raddr_q [$];
  logic [DW-1:0]  exp_rdata_q [$];
  bit             exp_rlast_q [$];
  logic [DW-1:0]  wbuf [16];
  logic [DW-1:0]  last_rsp_data = '0;
  int             rd_issue_cnt = 0;
  int             rsp_cnt = 0;
  bit             hold_rsp = 1'b0;
  bit             rand_rsp = 1'b0;

  // ---------------- monitor (samples on the falling edge) ----------------
  always @(negedge clock) begin
    if (resetn) begin
      if (wdata_valid && wdata_ready) begin
        chk("wr_expected", 64'(exp_waddr_q.size() > 0), 1);
        if (exp_waddr_q.size() > 0) begin
          chk("wr_enable", 64'(bank_enable), 1);
          chk("wr_addr", 64'(bank_address), 64'(exp_waddr_q.pop_front()));
          chk("wr_lanes", 64'(bank_write_enable), 64'(exp_wmask_q.pop_front()));
          chk("wr_data", 64'(bank_write_data), 64'(wdata));
        end
      end else if (bank_enable) begin
        rd_issue_cnt++;
        chk("rd_expected", 64'(exp_raddr_q.size() > 0), 1);
        if (exp_raddr_q.size() > 0) begin
          chk("rd_addr", 64'(bank_address), 64'(exp_raddr_q.pop_front()));
          chk("rd_lanes", 64'(bank_write_enable), 0);
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        chk("rsp_expected", 64'(exp_rdata_q.size() > 0), 1);
        if (exp_rdata_q.size() > 0) begin
          chk("rsp_data", 64'(rsp_data), 64'(exp_rdata_q.pop_front()));
          chk("rsp_last", 64'(rsp_last), 64'(exp_rlast_q.pop_front()));
          if (!rsp_last) chk("req_ready_busy", 64'(req_ready), 0);
        end
        last_rsp_data = rsp_data;
      end
    end
  end

  // ---------------- rsp_ready driver ----------------
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!hold_rsp) rsp_ready = rand_rsp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus tasks (called at posedge+1) ----------------
  task automatic clear_expect();
    exp_waddr_q.delete();
    exp_wmask_q.delete();
    exp_raddr_q.delete();
    exp_rdata_q.delete();
    exp_rlast_q.delete();
  endtask

  task automatic send_cmd(input bit wr, input int addr, input int len, input logic [NBC-1:0] mask);
    int n;
    int a;
    bit ok;
    n  = (len == 0) ? 1 : len;
    a  = addr;
    ok = 1'b0;
    if (!wr) begin
      for (int i = 0; i < n; i++) begin
        exp_raddr_q.push_back(AW'(a));
        exp_rdata_q.push_back(ref_mem[a]);
        exp_rlast_q.push_back(i == n - 1);
        a = (a + 1) % SIZE;
      end
    end
    req_valid   = 1'b1;
    req_write   = wr;
    req_address = AW'(addr);
    req_length  = LW'(len);
    req_mask    = mask;
    for (int k = 0; k < 500; k++) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("req_accept", 64'(ok), 1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic do_write(input int addr, input int len, input logic [NBC-1:0] mask, input bit gaps);
    int n;
    int a;
    bit ok;
    n = (len == 0) ? 1 : len;
    a = addr;
    send_cmd(1'b1, addr, len, mask);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        wdata_valid = 1'b0;
        repeat (g) begin
          @(posedge clock);
          #1;
        end
      end
      wdata_valid = 1'b1;
      wdata       = wbuf[i];
      exp_waddr_q.push_back(AW'(a));
      exp_wmask_q.push_back(mask);
      for (int l = 0; l < NBC; l++) begin
        if (mask[l]) ref_mem[a][l*8 +: 8] = wbuf[i][l*8 +: 8];
      end
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clock);
        if (wdata_ready) begin
          ok = 1'b1;
          break;
        end
      end
      chk("wbeat_accept", 64'(ok), 1);
      @(posedge clock);
      #1;
      wdata_valid = 1'b0;
      a = (a + 1) % SIZE;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock);
      if (exp_rdata_q.size() == 0 && req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", 64'(ok), 1);
    chk("issues_done", 64'(exp_raddr_q.size() + exp_waddr_q.size()), 0);
    if (!ok) clear_expect();
    @(posedge clock);
    #1;
  endtask

  // Read burst; reports issue-to-valid latency and longest rsp_valid run.
  task automatic read_measure(input int addr, input int len, output int lat, output int run_max);
    int first_issue;
    int first_rsp;
    int run;
    first_issue = -1;
    first_rsp   = -1;
    run         = 0;
    run_max     = 0;
    send_cmd(1'b0, addr, len, '1);
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (first_issue < 0 && bank_enable && !(wdata_valid && wdata_ready)) first_issue = k;
      if (rsp_valid) begin
        if (first_rsp < 0) first_rsp = k;
        run++;
        if (run > run_max) run_max = run;
      end else begin
        run = 0;
      end
      if (exp_rdata_q.size() == 0 && req_ready) break;
    end
    lat = (first_issue < 0 || first_rsp < 0) ? -1 : first_rsp - first_issue;
    wait_idle();
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 0);
    chk({tag, "_wdata_ready"}, 64'(wdata_ready), 0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
    chk({tag, "_rsp_last"}, 64'(rsp_last), 0);
    chk({tag, "_bank_enable"}, 64'(bank_enable), 0);
    chk({tag, "_bank_we"}, 64'(bank_write_enable), 0);
  endtask

  task automatic fill_random(input int addr, input int len);
    for (int i = 0; i < 16; i++) wbuf[i] = $urandom();
    do_write(addr, len, '1, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int run;
    int base;
    bit ok;
    resetn      = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_address = '0;
    req_length  = '0;
    req_mask    = '0;
    wdata_valid = 1'b0;
    wdata       = '0;
    bank_read_data = '0;
    for (int i = 0; i < SIZE; i++) begin
      bank_mem[i] = '0;
      ref_mem[i]  = '0;
    end

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_quiet("reset");
    @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    chk("idle_req_ready", 64'(req_ready), 1);
    @(posedge clock);
    #1;

    // write then read back
    wbuf[0] = 32'hDEADBEEF;
    do_write(5, 1, 4'hF, 1'b0);
    read_measure(5, 1, lat, run);
    chk("single_latency", 64'(lat), 2);
    chk("single_data", 64'(last_rsp_data), 64'h0000_0000_DEAD_BEEF);

    // partial write merges lanes 0 and 2
    wbuf[0] = 32'h11223344;
    do_write(7, 1, 4'hF, 1'b0);
    wbuf[0] = 32'hAABBCCDD;
    do_write(7, 1, 4'b0101, 1'b0);
    read_measure(7, 1, lat, run);
    chk("partial_data", 64'(last_rsp_data), 64'h0000_0000_11BB_33DD);

    // wrapping burst 1022 -> 1
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    do_write(1022, 4, 4'hF, 1'b0);
    read_measure(1022, 4, lat, run);
    chk("wrap_final_data", 64'(last_rsp_data), 4);

    // backpressure: 5 stalled cycles, only two reads may be outstanding
    fill_random(100, 8);
    hold_rsp  = 1'b1;
    rsp_ready = 1'b0;
    base = rd_issue_cnt;
    send_cmd(1'b0, 100, 8, '1);
    repeat (5) @(negedge clock);
    chk("stall_issues", 64'(rd_issue_cnt - base), 2);
    chk("stall_req_ready", 64'(req_ready), 0);
    @(posedge clock);
    #1;
    hold_rsp  = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();

    // full-rate read of a maximal burst
    fill_random(200, 16);
    read_measure(200, 16, lat, run);
    chk("burst16_run", 64'(run), 16);
    chk("burst16_latency", 64'(lat), 2);

    // zero length means one beat
    base = rsp_cnt;
    read_measure(300, 0, lat, run);
    chk("len0_beats", 64'(rsp_cnt - base), 1);

    // reset in the middle of a read burst
    fill_random(400, 8);
    base = rd_issue_cnt;
    ok = 1'b0;
    send_cmd(1'b0, 400, 8, '1);
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      #1;
      if (rd_issue_cnt - base >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_third_beat", 64'(ok), 1);
    resetn = 1'b0;
    clear_expect();
    @(negedge clock);
    check_quiet("midreset");
    @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    chk("post_reset_ready", 64'(req_ready), 1);
    @(posedge clock);
    #1;
    base = rsp_cnt;
    read_measure(400, 8, lat, run);
    chk("fresh_beats", 64'(rsp_cnt - base), 8);
    chk("fresh_final_data", 64'(last_rsp_data), 64'(wbuf[7]));

    // randomized traffic with random backpressure and write gaps
    rand_rsp = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int a;
      int len;
      logic [NBC-1:0] m;
      a   = $urandom_range(0, SIZE - 1);
      len = $urandom_range(0, 16);
      m   = NBC'($urandom());
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) wbuf[i] = $urandom();
        do_write(a, len, m, 1'b1);
      end else begin
        send_cmd(1'b0, a, len, m);
        wait_idle();
      end
    end
    rand_rsp = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
